// File: rtl/mux_nt1_rr_if.sv
// Handshake bundle between N producers, the mux_nt1_rr register and its consumer.
// The slave modport is the mux's view; the master modport is the producers'/consumer's view.
interface mux_nt1_rr_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(N)
);
  logic [N*WIDTH-1:0] In;
  logic [N-1:0]       Valid_in;
  logic [N-1:0]       Ready_in;
  logic [SW-1:0]      Sel;
  logic [WIDTH-1:0]   F;
  logic               Valid_F;
  logic               Ready_F;
  logic [SW-1:0]      Sel_F;

  modport slave (
    input  In, Valid_in, Sel, Ready_F,
    output Ready_in, F, Valid_F, Sel_F
  );

  modport master (
    output In, Valid_in, Sel, Ready_F,
    input  Ready_in, F, Valid_F, Sel_F
  );
endinterface

// File: rtl/mux_nt1_rr.sv
// Registered N:1 mux with per-channel valid/ready, fixed-select or round-robin grant.
// Define MUX_NT1_CNT_EN to add the 16-bit accepted-word Count port.

// Per-channel slice: handshake ready and grant-masked data for the AND-OR mux.
module mux_nt1_rr_lane #(
  parameter int WIDTH = 8
) (
  input  logic             grant,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_masked
);
  assign ready       = load_en & grant;
  assign data_masked = grant ? data : '0;
endmodule

module mux_nt1_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 1,
  localparam int SW   = $clog2(N)
) (
  input  logic        Clk,
  input  logic        Rst_n,
  mux_nt1_rr_if.slave bus
`ifdef MUX_NT1_CNT_EN
  ,
  output logic [15:0] Count
`endif
);

  logic                      load_en;
  logic [N-1:0]              grant;
  logic                      any_grant;
  logic [SW-1:0]             gidx;
  logic [SW-1:0]             idx;
  logic [SW-1:0]             ptr;
  logic [N-1:0][WIDTH-1:0]   lane_data;
  logic [WIDTH-1:0]          din;
  logic [WIDTH-1:0]          f_q;
  logic                      valid_q;
  logic [SW-1:0]             sel_q;

  // Ready is held low while reset is asserted so no producer sees a false accept.
  assign load_en = (~valid_q | bus.Ready_F) & Rst_n;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    gidx      = '0;
    idx       = '0;
    if (MODE == 0) begin
      // Loop compare keeps an out-of-range Sel from indexing past Valid_in.
      for (int i = 0; i < N; i++) begin
        if (bus.Sel == SW'(i) && bus.Valid_in[i]) begin
          grant[i]  = 1'b1;
          any_grant = 1'b1;
          gidx      = SW'(i);
        end
      end
    end else begin
      // Search ptr+1, ptr+2, ... wrapping; ptr itself is checked last.
      for (int k = 1; k <= N; k++) begin
        idx = SW'((int'(ptr) + k) % N);
        if (!any_grant && bus.Valid_in[idx]) begin
          grant[idx] = 1'b1;
          any_grant  = 1'b1;
          gidx       = idx;
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_nt1_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .grant       (grant[i]),
      .load_en     (load_en),
      .data        (bus.In[i*WIDTH +: WIDTH]),
      .ready       (bus.Ready_in[i]),
      .data_masked (lane_data[i])
    );
  end

  always_comb begin
    din = '0;
    for (int i = 0; i < N; i++) din = din | lane_data[i];
  end

  // With no grant the register empties, but F/Sel_F keep their last word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      f_q     <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr     <= SW'(N - 1);
    end else if (load_en) begin
      valid_q <= any_grant;
      if (any_grant) begin
        f_q   <= din;
        sel_q <= gidx;
        if (MODE == 1) ptr <= gidx;
      end
    end
  end

`ifdef MUX_NT1_CNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  Count <= '0;
    else if (load_en && any_grant) Count <= Count + 16'd1;
  end
`endif

  assign bus.F       = f_q;
  assign bus.Valid_F = valid_q;
  assign bus.Sel_F   = sel_q;

endmodule

// File: tb/tb_mux_nt1_rr.sv
// Directed bench for mux_nt1_rr: one fixed-select and one round-robin instance.
module tb_mux_nt1_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 Clk = ~Clk;

  mux_nt1_rr_if #(.N(N), .WIDTH(W)) bus0 ();
  mux_nt1_rr_if #(.N(N), .WIDTH(W)) bus1 ();

`ifdef MUX_NT1_CNT_EN
  logic [15:0] count0, count1;
`endif

  mux_nt1_rr #(.N(N), .WIDTH(W), .MODE(0)) u_fixed (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus0)
`ifdef MUX_NT1_CNT_EN
    ,
    .Count (count0)
`endif
  );

  mux_nt1_rr #(.N(N), .WIDTH(W), .MODE(1)) u_rr (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus1)
`ifdef MUX_NT1_CNT_EN
    ,
    .Count (count1)
`endif
  );

  // Round-robin channel c carries 0xA0 + 0x11*c.
  function automatic logic [7:0] rr_data(input int c);
    return 8'(8'hA0 + 8'h11 * c);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    bus0.In = 32'h44332211; bus1.In = 32'hD3C2B1A0;
    bus0.Valid_in = '1; bus1.Valid_in = '1;
    bus0.Sel = '0; bus1.Sel = '0;
    bus0.Ready_F = 1'b1; bus1.Ready_F = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (bus1.Valid_F !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus1.Valid_F); end
      n_checks++; if (bus1.F !== 8'h00) begin n_fail++; $display("FAIL reset_f got=%h exp=00", bus1.F); end
      n_checks++; if (bus1.Sel_F !== 2'd0) begin n_fail++; $display("FAIL reset_self got=%0d exp=0", bus1.Sel_F); end
      n_checks++; if (bus1.Ready_in !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_rr got=%b exp=0000", bus1.Ready_in); end
      n_checks++; if (bus0.Ready_in !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_fx got=%b exp=0000", bus0.Ready_in); end
    end
    Rst_n = 1'b1;
    #1;
    step();
    n_checks++; if (bus1.Sel_F !== 2'd0 || bus1.Valid_F !== 1'b1) begin n_fail++; $display("FAIL first_grant got=%0d/%0b exp=0/1", bus1.Sel_F, bus1.Valid_F); end
    n_checks++; if (bus1.F !== 8'hA0) begin n_fail++; $display("FAIL first_data got=%h exp=a0", bus1.F); end
  endtask

  task automatic test_fixed();
    bus0.Sel = 2'd2;
    #1;
    n_checks++; if (bus0.Ready_in !== 4'b0100) begin n_fail++; $display("FAIL fixed_ready got=%b exp=0100", bus0.Ready_in); end
    step();
    n_checks++; if (bus0.F !== 8'h33 || bus0.Sel_F !== 2'd2) begin n_fail++; $display("FAIL fixed_sel2 got=%h/%0d exp=33/2", bus0.F, bus0.Sel_F); end
    bus0.Sel = 2'd1;
    #1;
    n_checks++; if (bus0.Ready_in !== 4'b0010) begin n_fail++; $display("FAIL fixed_ready1 got=%b exp=0010", bus0.Ready_in); end
    step();
    n_checks++; if (bus0.F !== 8'h22 || bus0.Sel_F !== 2'd1) begin n_fail++; $display("FAIL fixed_sel1 got=%h/%0d exp=22/1", bus0.F, bus0.Sel_F); end
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    Rst_n = 1'b0; #2; Rst_n = 1'b1;
    bus1.Valid_in = '1; bus1.Ready_F = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      n_checks++;
      if (bus1.Sel_F !== 2'(exp_seq[j]) || bus1.Valid_F !== 1'b1 || bus1.F !== rr_data(exp_seq[j])) begin
        n_fail++; $display("FAIL rr_seq[%0d] got=%0d/%0b/%h exp=%0d/1/%h", j, bus1.Sel_F, bus1.Valid_F, bus1.F, exp_seq[j], rr_data(exp_seq[j]));
      end
    end
  endtask

  task automatic test_stall();
    bus1.Ready_F = 1'b0;
    #1;
    n_checks++; if (bus1.Ready_in !== 4'b0000) begin n_fail++; $display("FAIL stall_ready got=%b exp=0000", bus1.Ready_in); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus1.Sel_F !== 2'd1 || bus1.F !== 8'hB1 || bus1.Valid_F !== 1'b1 || bus1.Ready_in !== 4'b0000) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%0d/%h/%0b/%b exp=1/b1/1/0000", c, bus1.Sel_F, bus1.F, bus1.Valid_F, bus1.Ready_in);
      end
    end
    bus1.Ready_F = 1'b1;
    #1;
    n_checks++; if (bus1.Ready_in !== 4'b0100) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=0100", bus1.Ready_in); end
    step();
    n_checks++; if (bus1.Sel_F !== 2'd2 || bus1.Valid_F !== 1'b1) begin n_fail++; $display("FAIL stall_resume got=%0d/%0b exp=2/1", bus1.Sel_F, bus1.Valid_F); end
    step();
    n_checks++; if (bus1.Sel_F !== 2'd3 || bus1.F !== 8'hD3) begin n_fail++; $display("FAIL stall_next got=%0d/%h exp=3/d3", bus1.Sel_F, bus1.F); end
  endtask

  task automatic test_sparse();
    bus1.Valid_in = 4'b1000;
    #1;
    n_checks++; if (bus1.Ready_in !== 4'b1000) begin n_fail++; $display("FAIL sparse_ready3 got=%b exp=1000", bus1.Ready_in); end
    step();
    n_checks++; if (bus1.Sel_F !== 2'd3 || bus1.F !== 8'hD3) begin n_fail++; $display("FAIL sparse_g3 got=%0d/%h exp=3/d3", bus1.Sel_F, bus1.F); end
    step();
    n_checks++; if (bus1.Sel_F !== 2'd3 || bus1.Valid_F !== 1'b1) begin n_fail++; $display("FAIL sparse_repeat got=%0d/%0b exp=3/1", bus1.Sel_F, bus1.Valid_F); end
    bus1.Valid_in = 4'b0010;
    step();
    n_checks++; if (bus1.Sel_F !== 2'd1 || bus1.F !== 8'hB1) begin n_fail++; $display("FAIL sparse_wrap got=%0d/%h exp=1/b1", bus1.Sel_F, bus1.F); end
    bus1.Valid_in = 4'b0000;
    bus0.Valid_in = 4'b1011; bus0.Sel = 2'd2;
    #1;
    n_checks++; if (bus1.Ready_in !== 4'b0000) begin n_fail++; $display("FAIL idle_ready got=%b exp=0000", bus1.Ready_in); end
    n_checks++; if (bus0.Ready_in !== 4'b0000) begin n_fail++; $display("FAIL fixed_invalid_ready got=%b exp=0000", bus0.Ready_in); end
    step();
    n_checks++; if (bus1.Valid_F !== 1'b0 || bus1.Sel_F !== 2'd1 || bus1.F !== 8'hB1) begin n_fail++; $display("FAIL idle_bubble got=%0b/%0d/%h exp=0/1/b1", bus1.Valid_F, bus1.Sel_F, bus1.F); end
    n_checks++; if (bus0.Valid_F !== 1'b0) begin n_fail++; $display("FAIL fixed_invalid_valid got=%0b exp=0", bus0.Valid_F); end
  endtask

  task automatic test_count_reset();
    Rst_n = 1'b0; #2; Rst_n = 1'b1;
    bus1.Valid_in = '1; bus1.Ready_F = 1'b1;
    for (int c = 0; c < 10; c++) step();
`ifdef MUX_NT1_CNT_EN
    n_checks++; if (count1 !== 16'd10) begin n_fail++; $display("FAIL count_10 got=%0d exp=10", count1); end
`endif
    n_checks++; if (bus1.Valid_F !== 1'b1 || bus1.Sel_F !== 2'd1) begin n_fail++; $display("FAIL pre_reset got=%0b/%0d exp=1/1", bus1.Valid_F, bus1.Sel_F); end
    Rst_n = 1'b0;
    #1;
`ifdef MUX_NT1_CNT_EN
    n_checks++; if (count1 !== 16'd0) begin n_fail++; $display("FAIL count_reset got=%0d exp=0", count1); end
`endif
    n_checks++; if (bus1.Valid_F !== 1'b0 || bus1.F !== 8'h00 || bus1.Sel_F !== 2'd0) begin n_fail++; $display("FAIL async_reset got=%0b/%h/%0d exp=0/00/0", bus1.Valid_F, bus1.F, bus1.Sel_F); end
    #1;
    Rst_n = 1'b1;
    step();
    n_checks++; if (bus1.Sel_F !== 2'd0 || bus1.Valid_F !== 1'b1) begin n_fail++; $display("FAIL post_reset_grant got=%0d/%0b exp=0/1", bus1.Sel_F, bus1.Valid_F); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_stall();
    test_sparse();
    test_count_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_nt1_rr.md
# mux_nt1_rr

Parametrised, registered N:1 multiplexer with per-channel valid/ready handshakes, the sequential successor to the combinational 2:1 mux. It selects one of `N` input channels each cycle, either from an external select (fixed mode) or by round-robin arbitration, and presents the chosen word on a one-deep output register. It sits between multiple producers and a single consumer, e.g. several datapath sources sharing one bus.

## Interface
- `N`, default 4: number of input channels, 2..16.
- `WIDTH`, default 8: data width per channel, ≥1.
- `MODE`, default 1: 0 = fixed select via `Sel`; 1 = round-robin.
- `SW`, derived, `$clog2(N)`: select/index width.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: asynchronous reset, active low.
- `In` in N*WIDTH: channel i data at bits [i*WIDTH +: WIDTH].
- `Valid_in` in N: channel i offers a word.
- `Ready_in` out N: channel i word accepted this cycle when `Valid_in[i]` and `Ready_in[i]`.
- `Sel` in SW: channel select, used only when MODE=0.
- `F` out WIDTH: registered output data.
- `Valid_F` out 1: `F` holds a valid word.
- `Ready_F` in 1: consumer accepts `F` this cycle.
- `Sel_F` out SW: index of the channel that supplied `F`.
- `Count` out 16: accepted-word counter, present only with `MUX_NT1_CNT_EN`.

## Operation
- Output register loads when `load_en = !Valid_F | Ready_F`.
- Grant (combinational, one-hot, at most one bit):
  - MODE=0: grant `Sel` if `Valid_in[Sel]`; `Sel ≥ N` gives no grant.
  - MODE=1: search from `ptr+1` upward modulo N; the first channel with `Valid_in` set is granted.
- `Ready_in[i] = load_en & grant[i]`. A channel that is not granted sees `Ready_in` = 0.
- On accept:
  - `F` ← `In[g]`, `Sel_F` ← g, `Valid_F` ← 1.
  - MODE=1: `ptr` ← g.
- If `load_en` is high and no channel is granted, `Valid_F` ← 0. `F` and `Sel_F` hold their previous values.
- `ptr` changes only on an accepted word. It never moves while the register is stalled.
- Producers must hold `In`/`Valid_in` stable until accepted. Consumers must not depend on `F` while `Valid_F` = 0.
- Reset values: `F`=0, `Valid_F`=0, `Sel_F`=0, `ptr`=N-1 (first search starts at channel 0), `Count`=0.

## Timing
- Latency: a word accepted at edge k appears on `F`/`Valid_F` immediately after edge k. There is 1 cycle from `Valid_in` to `Valid_F`.
- Throughput: 1 word/cycle while `Ready_F`=1. A simultaneous drain and load in the same cycle is required and must not produce a bubble.
- Stall: `Valid_F`=1 and `Ready_F`=0 ⇒ all `Ready_in`=0. `F`, `Sel_F`, and `ptr` hold.
- Round-robin fairness: with all N channels continuously valid, grants cycle 0,1,…,N-1,0. No channel waits more than N-1 accepts.
- Wrap-around: `ptr`=N-1 ⇒ search begins at 0.
- Single requester: the same channel may be granted on consecutive cycles.
- Reset mid-operation: `Rst_n` low clears the register immediately, asynchronously to `Clk`. A word held in `F` is discarded and not re-offered. Release of reset is synchronous in effect: the first load can occur at the first rising edge with `Rst_n`=1.

## Configuration
- `MUX_NT1_CNT_EN` defined:
  - The `Count` port exists.
  - `Count` increments by 1 on every accepted input word and wraps 0xFFFF→0x0000.
  - `Count` resets to 0.
- `MUX_NT1_CNT_EN` undefined:
  - No `Count` port and no counter logic.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: hold `Rst_n`=0 with all `Valid_in`=1.
  - Required: `Valid_F`=0, `F`=0, `Sel_F`=0, `Ready_in`=0 all the time; after release the first grant is channel 0.
- MODE=0, N=4, WIDTH=8:
  - Stimulus: `In`={0x44,0x33,0x22,0x11}, all valid, `Ready_F`=1, `Sel`=2.
  - Required: next cycle `F`=0x33, `Sel_F`=2, `Ready_in`=4'b0100.
- MODE=1, all four channels valid, `Ready_F`=1 continuously:
  - Required: `Sel_F` sequence 0,1,2,3,0,1; `Valid_F`=1 every cycle after the first.
- MODE=1 stall:
  - Stimulus: `Ready_F`=0 for 3 cycles while `Valid_F`=1.
  - Required: `F`, `Sel_F`, and `ptr` unchanged; `Ready_in`=0; on `Ready_F`=1 the next channel is granted with no bubble.
- Sparse requests:
  - Stimulus: only channel 3 valid, then only channel 1.
  - Required: grant 3, then grant 1 (wrap); a cycle with no valid channel and `Ready_F`=1 gives `Valid_F`=0.
- With `MUX_NT1_CNT_EN`:
  - Stimulus: 10 accepts, then assert `Rst_n`=0 mid-stream.
  - Required: `Count`=10 before reset; `Count`=0 and `Valid_F`=0 immediately on reset.
